// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a byte-wide registered-read RAM port between instruction fetch and
// the load/store buffer, serializing one granted transaction at a time into byte accesses.
module mem_arbiter #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [AddrWidth-1:0] if_addr,
  input  logic                 ls_req,
  input  logic                 ls_is_store,
  input  logic [1:0]           ls_size,
  input  logic [AddrWidth-1:0] ls_addr,
  input  logic [DataWidth-1:0] ls_wdata,
  input  logic                 flush,
  input  logic [7:0]           ram_din,
  output logic [AddrWidth-1:0] ram_addr,
  output logic [7:0]           ram_dout,
  output logic                 ram_wr,
  output logic                 if_done,
  output logic [DataWidth-1:0] if_rdata,
  output logic                 ls_done,
  output logic [DataWidth-1:0] ls_rdata,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state;
  logic last_ls, cur_ls, if_ok, ls_ok, pick_ls;
  logic [2:0] cnt, num, ls_num, bidx;
  logic [AddrWidth-1:0] base;
  logic [DataWidth-1:0] wbuf, rbuf, merged;
  // a flush blocks speculative reads from being granted, but never a committed store
  always_comb begin
    if_ok = if_req & ~flush;
    ls_ok = ls_req & (~flush | ls_is_store);
    pick_ls = ls_ok & (~if_ok | ~last_ls);
    ls_num = ls_size == 2'b00 ? 3'd1 : ls_size == 2'b01 ? 3'd2 : 3'd4;
    bidx = cnt - 3'd2;
    merged = rbuf;
    merged[{bidx[1:0], 3'b000} +: 8] = ram_din;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      last_ls <= 1'b0;
      cur_ls <= 1'b0;
      cnt <= '0;
      num <= '0;
      base <= '0;
      wbuf <= '0;
      rbuf <= '0;
      ram_addr <= '0;
      ram_dout <= '0;
      ram_wr <= 1'b0;
      if_done <= 1'b0;
      if_rdata <= '0;
      ls_done <= 1'b0;
      ls_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (if_ok | ls_ok) begin
          last_ls <= pick_ls;
          cur_ls <= pick_ls;
          cnt <= 3'd1;
          rbuf <= '0;
          base <= pick_ls ? ls_addr : if_addr;
          ram_addr <= pick_ls ? ls_addr : if_addr;
          num <= pick_ls ? ls_num : 3'd4;
          if (pick_ls && ls_is_store) begin
            state <= WRITE;
            ram_wr <= 1'b1;
            ram_dout <= ls_wdata[7:0];
            wbuf <= ls_wdata >> 8;
          end else begin
            state <= READ;
          end
        end
        // cnt is the edge index since grant; byte k returns two edges after its address
        READ: if (flush) begin
          state <= IDLE;
          cnt <= '0;
          ram_wr <= 1'b0;
        end else begin
          if (cnt < num) ram_addr <= base + AddrWidth'(cnt);
          if (cnt >= 3'd2) rbuf <= merged;
          if (cnt == num + 3'd1) begin
            state <= DONE;
            cnt <= '0;
            if (cur_ls) begin
              ls_done <= 1'b1;
              ls_rdata <= merged;
            end else begin
              if_done <= 1'b1;
              if_rdata <= merged;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        WRITE: if (cnt == num) begin
          state <= DONE;
          cnt <= '0;
          ram_wr <= 1'b0;
          ls_done <= 1'b1;
        end else begin
          ram_addr <= base + AddrWidth'(cnt);
          ram_dout <= wbuf[7:0];
          wbuf <= wbuf >> 8;
          cnt <= cnt + 3'd1;
        end
        default: begin
          state <= IDLE;
          if_done <= 1'b0;
          ls_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM port and shares it between two requesters.
- Requesters are instruction fetch (4-byte reads) and the store/load buffer (1/2/4-byte loads and stores).
- Grants one whole transaction at a time, fairly, and serializes it into byte accesses.
- Honors ROB exception flush: speculative reads are aborted; committed stores run to completion.

Parameters:
AddrWidth, 32, RAM/transaction address width; all address arithmetic wraps modulo 2^AddrWidth
DataWidth, 32, transaction data width (4 bytes)

Ports:
clk  input  1  clock, all state changes on posedge
rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
if_req  input  1  fetch request, level, held until if_done
if_addr  input  AddrWidth  fetch address, sampled at grant
ls_req  input  1  load/store request, level, held until ls_done
ls_is_store  input  1  1 = store, 0 = load, sampled at grant
ls_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
ls_addr  input  AddrWidth  load/store address, sampled at grant
ls_wdata  input  DataWidth  store data, byte 0 = [7:0], sampled at grant
flush  input  1  ROB exception
ram_din  input  8  RAM read byte; RAM has 1-cycle registered read
ram_addr  output  AddrWidth  registered
ram_dout  output  8  registered
ram_wr  output  1  registered write enable
if_done  output  1  one-cycle pulse, if_rdata valid
if_rdata  output  DataWidth  fetched word
ls_done  output  1  one-cycle pulse, ls_rdata valid (loads) / store complete
ls_rdata  output  DataWidth  load data, bytes above size zero-filled
busy  output  1  high in any state but IDLE

Behaviour:
- Reset (rst=0 at posedge): state IDLE; all outputs 0; last_grant = IF; byte counter 0; in-flight op discarded, including stores mid-way.
- FSM states:
  - IDLE: grant, or stay.
  - READ: issue and capture bytes.
  - WRITE: issue bytes.
  - DONE: one cycle; done pulse high; no grant.
  - DONE always returns to IDLE.
- Arbitration in IDLE:
  - Only one req high: grant it.
  - Both high: grant the requester not equal to last_grant; last_grant updated at each grant.
  - First tie after reset goes to LS.
  - Fields are latched at the grant edge; later changes on request inputs are ignored.
- N = bytes: fetch 4; ls_size 00→1, 01→2, 10/11→4.
- Read, grant at edge 0:
  - ram_addr <= A at edge 0, A+k at edge k (k < N); ram_wr stays 0.
  - Byte k is captured from ram_din at edge k+2 into bits [8k+7:8k].
  - At edge N+1: last byte merged, done pulse and rdata set, state DONE.
  - Done is high during the cycle after edge N+1 (word read: after edge 5).
- Write, grant at edge 0:
  - ram_wr <= 1; ram_addr <= A+k and ram_dout <= byte k at edge k (k < N).
  - At edge N: ram_wr <= 0, ls_done <= 1, state DONE.
- Next grant possible at the edge ending DONE. Requesters drop req at the edge where done is high; a req still high after DONE is treated as a new request.
- rdata registers hold their value until the next completion of the same requester.
- flush=1 at an edge:
  - READ: abort, state IDLE, ram_wr 0, no done pulse, counter cleared.
  - WRITE or DONE of a store: unaffected; the store completes and ls_done pulses.
  - IDLE: if_req and load requests are not granted that cycle; a store ls_req may be granted.
  - DONE of a read: done pulse still delivered.
- Address wrap: A = 2^AddrWidth-1, k=1 gives address 0.
- ram_dout is don't-care (held) when ram_wr=0.

Test Plan:
1. Fetch at 0x1000, RAM bytes 13,00,00,00; if_req alone → ram_addr 0x1000..0x1003 on edges 0–3; if_done high after edge 5 with if_rdata 0x00000013; ram_wr never 1.
2. Store half 0xBEEF to 0x20, size 01 → ram_wr=1 for 2 cycles: (0x20,EF), (0x21,BE); ls_done after edge 2; busy low 2 cycles later.
3. Both req high after reset, held, new requests re-raised immediately → grant order LS, IF, LS, IF; exactly one done pulse per transaction; no overlap of RAM activity.
4. Load word at 0x40; flush at edge 3 → no ls_done, state IDLE next cycle, ram_wr 0; re-issued load completes normally with the correct word.
5. Store word 0x11223344 at 0x80; flush at edge 1 → all four bytes 44,33,22,11 written to 0x80..0x83; ls_done pulses; pending if_req is not granted in the flush cycle.
6. rst=0 during byte 2 of a store → next cycle all outputs 0, state IDLE; with rst=1 and both reqs high, the first grant goes to LS.
